// File: rtl/capture_pkg.sv
// Shared types and sizing for the DSO capture sequencer.
package capture_pkg;

    localparam int ENTRIES = 512;
    localparam int AW      = 9;
    localparam int DECW    = 4;
    // Decimation counter must reach 2^(2^DECW - 1) - 1.
    localparam int DCW     = (1 << DECW) - 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Control, trigger handshake and sample-RAM write signals of the capture sequencer.
interface capture_ctrl_if;
    import capture_pkg::*;

    logic            run;
    logic            abort;
    logic            clr_capture_done;
    logic [AW-1:0]   trig_pos;
    logic [DECW-1:0] decimator;
    logic            triggered;
    logic            armed;
    logic            trig_en;
    logic            set_capture_done;
    logic            capture_done;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   trace_end;

    modport master (
        output run, abort, clr_capture_done, trig_pos, decimator, triggered,
        input  armed, trig_en, set_capture_done, capture_done, we, waddr, trace_end
    );

    modport slave (
        input  run, abort, clr_capture_done, trig_pos, decimator, triggered,
        output armed, trig_en, set_capture_done, capture_done, we, waddr, trace_end
    );

endinterface

// File: rtl/capture_ctrl_smpl_strobe_gen.sv
// Decimation strobe: one smpl_en every 2^decimator enabled clocks, restartable by i_clr.
module smpl_strobe_gen
    import capture_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_clr,
    input  logic [DECW-1:0] i_decimator,
    output logic            o_smpl_en
);

    logic [DCW-1:0] r_dec_cnt;
    logic [DCW-1:0] w_dec_max;

    assign w_dec_max = DCW'((32'd1 << i_decimator) - 32'd1);
    assign o_smpl_en = i_en && (r_dec_cnt == w_dec_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= '0;
        end else if (i_clr) begin
            r_dec_cnt <= '0;
        end else if (i_en) begin
            r_dec_cnt <= o_smpl_en ? '0 : r_dec_cnt + DCW'(1);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: paces decimated writes into the circular sample RAM, arms and
// enables the trigger, counts post-trigger samples and reports the trace end address.
//
// state | meaning
// IDLE  | waiting for run; no writes, trigger disabled
// PRE   | filling pre-trigger history, not yet armed
// WAIT  | armed, still writing, waiting for triggered
// POST  | counting trig_pos post-trigger writes
// DONE  | trace frozen, capture_done held until clr_capture_done
module capture_ctrl
    import capture_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    capture_ctrl_if.slave  cap
);

    cap_state_t    r_state;
    cap_state_t    w_state_nxt;

    logic          w_active;
    logic          w_smpl_en;
    logic          w_run_go;
    logic          w_enter_done;
    logic          w_pre_reached;
    logic          w_post_hit;
    logic [AW-1:0] w_waddr_nxt;
    logic          w_armed_nxt;
    logic          w_trig_en_nxt;

    logic [AW:0]   r_smpl_cnt;
    logic [AW-1:0] r_post_cnt;
    logic [AW-1:0] r_waddr;
    logic [AW-1:0] r_trace_end;
    logic          r_armed;
    logic          r_trig_en;
    logic          r_set_done;
    logic          r_capture_done;

    assign w_active = (r_state == PRE) || (r_state == WAIT) || (r_state == POST);

    smpl_strobe_gen u_strobe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_active),
        .i_clr       (w_run_go),
        .i_decimator (cap.decimator),
        .o_smpl_en   (w_smpl_en)
    );

    // trig_pos = 0 needs the whole RAM filled before arming.
    assign w_pre_reached = r_smpl_cnt >= (AW+1)'(ENTRIES - int'(cap.trig_pos));
    assign w_post_hit    = w_smpl_en && ((r_post_cnt + AW'(1)) == cap.trig_pos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (cap.abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (cap.run)              w_state_nxt = PRE;
                PRE:     if (w_pre_reached)        w_state_nxt = WAIT;
                WAIT:    if (cap.triggered)        w_state_nxt = (cap.trig_pos == '0) ? DONE : POST;
                POST:    if (w_post_hit)           w_state_nxt = DONE;
                DONE:    if (cap.clr_capture_done) w_state_nxt = IDLE;
                default:                           w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_run_go      = (r_state == IDLE) && cap.run && !cap.abort;
        w_enter_done  = (w_state_nxt == DONE) && (r_state != DONE);
        w_waddr_nxt   = w_smpl_en ? r_waddr + AW'(1) : r_waddr;
        w_armed_nxt   = ((w_state_nxt == WAIT) || (w_state_nxt == POST)) && w_pre_reached;
        w_trig_en_nxt = (w_state_nxt == PRE) || (w_state_nxt == WAIT) || (w_state_nxt == POST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smpl_cnt     <= '0;
            r_post_cnt     <= '0;
            r_waddr        <= '0;
            r_trace_end    <= '0;
            r_armed        <= 1'b0;
            r_trig_en      <= 1'b0;
            r_set_done     <= 1'b0;
            r_capture_done <= 1'b0;
        end else begin
            r_armed        <= w_armed_nxt;
            r_trig_en      <= w_trig_en_nxt;
            r_set_done     <= w_enter_done;
            r_capture_done <= (w_state_nxt == DONE);
            // Last written address, including a write in the transition cycle itself.
            if (w_enter_done) begin
                r_trace_end <= w_waddr_nxt - AW'(1);
            end
            if (w_run_go) begin
                r_smpl_cnt <= '0;
                r_post_cnt <= '0;
                r_waddr    <= '0;
            end else if (w_smpl_en) begin
                r_waddr <= w_waddr_nxt;
                if (r_smpl_cnt != (AW+1)'(ENTRIES)) begin
                    r_smpl_cnt <= r_smpl_cnt + (AW+1)'(1);
                end
                if (r_state == POST) begin
                    r_post_cnt <= r_post_cnt + AW'(1);
                end
            end
        end
    end

    assign cap.we               = w_smpl_en;
    assign cap.waddr            = r_waddr;
    assign cap.trace_end        = r_trace_end;
    assign cap.armed            = r_armed;
    assign cap.trig_en          = r_trig_en;
    assign cap.set_capture_done = r_set_done;
    assign cap.capture_done     = r_capture_done;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: predicted writes and trace results are queued at stimulus time.
module tb_capture_ctrl;
    import capture_pkg::*;

    typedef struct {
        int addr;
        int cyc;
    } wr_exp_t;

    typedef struct {
        int te;
        int nw;
    } done_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    capture_ctrl_if cif();

    capture_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cap   (cif)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int n_cmp = 0;
    int n_mis = 0;
    int n_obs = 0;

    wr_exp_t   exp_wr_q[$];
    done_exp_t exp_done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic chk_outs_zero(input string pre);
        chk_eq({pre, "_armed"},     int'(cif.armed), 0);
        chk_eq({pre, "_trig_en"},   int'(cif.trig_en), 0);
        chk_eq({pre, "_scd"},       int'(cif.set_capture_done), 0);
        chk_eq({pre, "_cap_done"},  int'(cif.capture_done), 0);
        chk_eq({pre, "_we"},        int'(cif.we), 0);
        chk_eq({pre, "_waddr"},     int'(cif.waddr), 0);
        chk_eq({pre, "_trace_end"}, int'(cif.trace_end), 0);
    endtask

    always @(negedge clk) begin
        wr_exp_t   we_e;
        done_exp_t de;
        if (cif.we === 1'b1) begin
            n_obs++;
            if (exp_wr_q.size() == 0) begin
                chk_eq("we_unexpected", exp_wr_q.size(), 1);
            end else begin
                we_e = exp_wr_q.pop_front();
                chk_eq("we_cycle", cyc, we_e.cyc);
                chk_eq("waddr", int'(cif.waddr), we_e.addr);
            end
        end
        if (cif.set_capture_done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                chk_eq("scd_unexpected", exp_done_q.size(), 1);
            end else begin
                de = exp_done_q.pop_front();
                chk_eq("trace_end", int'(cif.trace_end), de.te);
                chk_eq("n_writes", n_obs, de.nw);
            end
        end
    end

    // mst: 0 = PRE, 1 = WAIT, 2 = POST
    task automatic capture(input int tp, input int dec, input int trig_wait, input bit trig_early,
                           input int abort_post, input int rst_post, input bit clr_with_run);
        int  d     = 1 << dec;
        int  thr   = ENTRIES - tp;
        int  t     = 0;
        int  n_wr  = 0;
        int  post  = 0;
        int  wait_t = 0;
        int  post_t = 0;
        int  mst   = 0;
        int  mcur;
        bit  wr;
        bit  trg;
        bit  done  = 1'b0;
        bit  quit  = 1'b0;
        bit  ab    = 1'b0;

        @(posedge clk); #1;
        cif.trig_pos  = AW'(tp);
        cif.decimator = DECW'(dec);
        cif.run       = 1'b1;
        n_obs         = 0;
        @(posedge clk); #1;
        cif.run = 1'b0;

        while (!done && !quit) begin
            if (t >= 30000) begin
                chk_eq("loop_budget", t, 0);
                quit = 1'b1;
            end else if (rst_post >= 0 && mst == 2 && post_t == rst_post) begin
                rst_n         = 1'b0;
                cif.triggered = 1'b0;
                #1;
                chk_outs_zero("rst_mid");
                @(negedge clk);
                rst_n = 1'b1;
                quit  = 1'b1;
            end else begin
                if (trig_early || (mst == 1 && wait_t >= trig_wait)) cif.triggered = 1'b1;
                cif.abort = (abort_post >= 0 && mst == 2 && post_t == abort_post);
                trg = cif.triggered;
                ab  = cif.abort;
                wr  = ((t + 1) % d) == 0;
                if (wr) exp_wr_q.push_back('{addr: n_wr % ENTRIES, cyc: cyc});
                @(negedge clk);
                chk_eq("armed", int'(cif.armed), int'(mst != 0));
                chk_eq("trig_en", int'(cif.trig_en), 1);
                chk_eq("cap_done_busy", int'(cif.capture_done), 0);
                mcur = mst;
                if (ab) begin
                    quit = 1'b1;
                end else if (mst == 0) begin
                    if (n_wr >= thr) mst = 1;
                end else if (mst == 1) begin
                    if (trg) begin
                        if (tp == 0) done = 1'b1;
                        else         mst = 2;
                    end
                    wait_t++;
                end else begin
                    if (wr && post + 1 == tp) done = 1'b1;
                    post_t++;
                end
                if (wr) begin
                    n_wr++;
                    if (mcur == 2) post++;
                end
                if (done) exp_done_q.push_back('{te: (n_wr - 1) % ENTRIES, nw: n_wr});
            end
            @(posedge clk); #1;
            t++;
        end

        cif.abort = 1'b0;
        if (done) begin
            @(negedge clk);
            chk_eq("done_cap_done", int'(cif.capture_done), 1);
            chk_eq("done_trig_en", int'(cif.trig_en), 0);
            chk_eq("done_armed", int'(cif.armed), 0);
            chk_eq("done_we", int'(cif.we), 0);
            @(posedge clk); #1;
            cif.triggered = 1'b0;
            cif.run       = !clr_with_run;
            @(negedge clk);
            chk_eq("scd_pulse_width", int'(cif.set_capture_done), 0);
            chk_eq("done_sticky", int'(cif.capture_done), 1);
            @(posedge clk); #1;
            cif.run = 1'b0;
            @(negedge clk);
            chk_eq("run_in_done_ignored", int'(cif.trig_en), 0);
            chk_eq("done_sticky2", int'(cif.capture_done), 1);
            @(posedge clk); #1;
            cif.clr_capture_done = 1'b1;
            cif.run              = clr_with_run;
            @(posedge clk); #1;
            cif.clr_capture_done = 1'b0;
            cif.run              = 1'b0;
            @(negedge clk);
            chk_eq("clr_cap_done", int'(cif.capture_done), 0);
            chk_eq("clr_trig_en", int'(cif.trig_en), 0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk_eq("idle_after_clr", int'(cif.trig_en), 0);
        end else begin
            cif.triggered = 1'b0;
            @(negedge clk);
            chk_eq("stop_trig_en", int'(cif.trig_en), 0);
            chk_eq("stop_armed", int'(cif.armed), 0);
            chk_eq("stop_cap_done", int'(cif.capture_done), 0);
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk_eq("stop_cap_done_late", int'(cif.capture_done), 0);
            chk_eq("stop_idle", int'(cif.trig_en), 0);
        end
        chk_eq("wr_q_left", exp_wr_q.size(), 0);
        chk_eq("done_q_left", exp_done_q.size(), 0);
        exp_wr_q.delete();
        exp_done_q.delete();
    endtask

    initial begin
        cif.run              = 1'b0;
        cif.abort            = 1'b0;
        cif.clr_capture_done = 1'b0;
        cif.triggered        = 1'b0;
        cif.trig_pos         = '0;
        cif.decimator        = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_outs_zero("post_reset");

        //      tp   dec trig_wait early abort rst  clr+run
        capture(256, 0,  343,      0,    -1,   -1,  0);
        capture(0,   0,  5,        0,    -1,   -1,  0);
        capture(300, 1,  400,      0,    -1,   -1,  0);
        capture(200, 3,  30,       0,    -1,   -1,  0);
        capture(128, 0,  0,        1,    -1,   -1,  0);
        capture(256, 0,  10,       0,    20,   -1,  0);
        capture(64,  2,  3,        0,    -1,   10,  0);
        capture(16,  0,  2,        0,    -1,   -1,  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
